axi_rd_arb_n: RTL and testbench

AXI_RD_ARB_N -- requirements
Module: axi_rd_arb_n

---
 rtl/axi_rd_arb_n.sv | 130 +++++++++++++
 tb/tb_axi_rd_arb_n.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb_n.sv
// axi_rd_arb_n: N-master AXI read arbiter that owns one AR plus its full R burst at a time
// Ports: clock/reset (sync, active-high); s_ar*/s_r* are per-master flattened slices, slot i at [i*W +: W];
//        m_ar*/m_r* is the single downstream read port; grant is the registered one-hot owner; busy is high outside IDLE.
module axi_rd_arb_n #(
  parameter int N_MST  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int RR     = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_MST-1:0]        s_arvalid,
  output logic [N_MST-1:0]        s_arready,
  input  logic [N_MST*ADDR_W-1:0] s_araddr,
  input  logic [N_MST*ID_W-1:0]   s_arid,
  input  logic [N_MST*8-1:0]      s_arlen,
  input  logic [N_MST*3-1:0]      s_arsize,
  input  logic [N_MST*2-1:0]      s_arburst,
  output logic [N_MST-1:0]        s_rvalid,
  output logic [N_MST-1:0]        s_rlast,
  input  logic [N_MST-1:0]        s_rready,
  output logic [N_MST*DATA_W-1:0] s_rdata,
  output logic [N_MST*2-1:0]      s_rresp,
  output logic [N_MST*ID_W-1:0]   s_rid,
  output logic                    m_arvalid,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [ID_W-1:0]         m_arid,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_rready,
  input  logic                    m_arready,
  input  logic                    m_rvalid,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic [ID_W-1:0]         m_rid,
  output logic [N_MST-1:0]        grant,
  output logic                    busy
);
  localparam int PW = $clog2(N_MST);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic [N_MST-1:0] grant_q, grant_d, win;
  logic [PW-1:0] ptr_q, ptr_d, win_nxt;
  logic found, a_st, d_st;
  // Search begins at ptr in round-robin mode, at slot 0 in fixed mode, wrapping modulo N_MST.
  always_comb begin : arb
    int j;
    j = 0;
    win = '0;
    win_nxt = '0;
    found = 1'b0;
    for (int k = 0; k < N_MST; k++) begin
      j = (RR != 0 ? int'(ptr_q) : 0) + k;
      j = j >= N_MST ? j - N_MST : j;
      if (!found && s_arvalid[j]) begin
        found = 1'b1;
        win[j] = 1'b1;
        win_nxt = j == N_MST - 1 ? '0 : PW'(j + 1);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    if (state_q == IDLE && found) begin
      state_d = ADDR;
      grant_d = win;
      ptr_d = win_nxt;
    end else if (state_q == ADDR && m_arvalid && m_arready) begin
      state_d = DATA;
    end else if (state_q == DATA && m_rvalid && m_rready && m_rlast) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
    end
  end
  // Outputs are gated by reset so everything reads 0 in the very cycle reset is high.
  assign a_st = !reset && state_q == ADDR;
  assign d_st = !reset && state_q == DATA;
  assign grant = reset ? '0 : grant_q;
  assign busy = !reset && state_q != IDLE;
  always_comb begin
    m_arvalid = 1'b0;
    m_araddr = '0;
    m_arid = '0;
    m_arlen = '0;
    m_arsize = '0;
    m_arburst = '0;
    m_rready = 1'b0;
    s_arready = '0;
    s_rvalid = '0;
    s_rlast = '0;
    s_rdata = '0;
    s_rresp = '0;
    s_rid = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (a_st && grant_q[i]) begin
        m_arvalid = s_arvalid[i];
        m_araddr = s_araddr[i*ADDR_W +: ADDR_W];
        m_arid = s_arid[i*ID_W +: ID_W];
        m_arlen = s_arlen[i*8 +: 8];
        m_arsize = s_arsize[i*3 +: 3];
        m_arburst = s_arburst[i*2 +: 2];
        s_arready[i] = m_arready;
      end
      if (d_st && grant_q[i]) begin
        m_rready = s_rready[i];
        s_rvalid[i] = m_rvalid;
        s_rlast[i] = m_rlast;
        s_rdata[i*DATA_W +: DATA_W] = m_rdata;
        s_rresp[i*2 +: 2] = m_rresp;
        s_rid[i*ID_W +: ID_W] = m_rid;
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_arb_n.sv
// tb_axi_rd_arb_n: bench for a fixed-priority 3-master and a round-robin 5-master arbiter sharing one stimulus
module tb_axi_rd_arb_n;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic [4:0] s_arvalid = '0, s_rready = '0;
  logic [159:0] s_araddr;
  logic [19:0] s_arid;
  logic [39:0] s_arlen;
  logic [14:0] s_arsize;
  logic [9:0] s_arburst;
  logic m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0] m_rresp = 2'b10;
  logic [3:0] m_rid = 4'hA;
  logic [2:0] a_s_arready, a_s_rvalid, a_s_rlast, a_grant;
  logic [95:0] a_s_rdata;
  logic [5:0] a_s_rresp;
  logic [11:0] a_s_rid;
  logic a_m_arvalid, a_m_rready, a_busy;
  logic [31:0] a_m_araddr;
  logic [3:0] a_m_arid;
  logic [7:0] a_m_arlen;
  logic [2:0] a_m_arsize;
  logic [1:0] a_m_arburst;
  logic [4:0] b_s_arready, b_s_rvalid, b_s_rlast, b_grant;
  logic [159:0] b_s_rdata;
  logic [9:0] b_s_rresp;
  logic [19:0] b_s_rid;
  logic b_m_arvalid, b_m_rready, b_busy;
  logic [31:0] b_m_araddr;
  logic [3:0] b_m_arid;
  logic [7:0] b_m_arlen;
  logic [2:0] b_m_arsize;
  logic [1:0] b_m_arburst;
  int checks = 0, failures = 0;

  axi_rd_arb_n #(.N_MST(3), .RR(0)) u_fp (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid[2:0]), .s_arready(a_s_arready), .s_araddr(s_araddr[95:0]), .s_arid(s_arid[11:0]),
    .s_arlen(s_arlen[23:0]), .s_arsize(s_arsize[8:0]), .s_arburst(s_arburst[5:0]),
    .s_rvalid(a_s_rvalid), .s_rlast(a_s_rlast), .s_rready(s_rready[2:0]), .s_rdata(a_s_rdata),
    .s_rresp(a_s_rresp), .s_rid(a_s_rid),
    .m_arvalid(a_m_arvalid), .m_araddr(a_m_araddr), .m_arid(a_m_arid), .m_arlen(a_m_arlen),
    .m_arsize(a_m_arsize), .m_arburst(a_m_arburst), .m_rready(a_m_rready),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid), .grant(a_grant), .busy(a_busy)
  );
  axi_rd_arb_n #(.N_MST(5), .RR(1)) u_rr (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(b_s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(b_s_rvalid), .s_rlast(b_s_rlast), .s_rready(s_rready), .s_rdata(b_s_rdata),
    .s_rresp(b_s_rresp), .s_rid(b_s_rid),
    .m_arvalid(b_m_arvalid), .m_araddr(b_m_araddr), .m_arid(b_m_arid), .m_arlen(b_m_arlen),
    .m_arsize(b_m_arsize), .m_arburst(b_m_arburst), .m_rready(b_m_rready),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid), .grant(b_grant), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: index 0 is the fixed-priority 3-slot arbiter, index 1 the round-robin 5-slot one.
  // st: 0 idle, 1 address phase, 2 data phase; own: owning slot; ptr: round-robin search start.
  int st[2] = '{0, 0};
  int own[2] = '{-1, -1};
  int ptr[2] = '{0, 0};
  typedef struct packed {
    logic [4:0] grant;
    logic busy;
    logic [49:0] mar;
    logic mrr;
    logic [4:0] sar, srv, srl;
    logic [159:0] srd;
    logic [9:0] srr;
    logic [19:0] sri;
  } exp_t;

  function automatic exp_t model_out(int i);
    exp_t e;
    int o;
    e = '0;
    o = own[i];
    if (!reset && st[i] != 0) begin
      e.grant[o] = 1'b1;
      e.busy = 1'b1;
    end
    if (!reset && st[i] == 1) begin
      e.mar = {s_arvalid[o], s_araddr[o*32 +: 32], s_arid[o*4 +: 4], s_arlen[o*8 +: 8], s_arsize[o*3 +: 3], s_arburst[o*2 +: 2]};
      e.sar[o] = m_arready;
    end
    if (!reset && st[i] == 2) begin
      e.mrr = s_rready[o];
      e.srv[o] = m_rvalid;
      e.srl[o] = m_rlast;
      e.srd[o*32 +: 32] = m_rdata;
      e.srr[o*2 +: 2] = m_rresp;
      e.sri[o*4 +: 4] = m_rid;
    end
    return e;
  endfunction

  task automatic model_step(input int i);
    int n;
    n = i ? 5 : 3;
    if (reset) begin
      st[i] = 0;
      own[i] = -1;
      ptr[i] = 0;
    end else if (st[i] == 0) begin
      for (int k = 0; k < n; k++) begin
        int j = ((i ? ptr[i] : 0) + k) % n;
        if (st[i] == 0 && s_arvalid[j]) begin
          st[i] = 1;
          own[i] = j;
          ptr[i] = (j + 1) % n;
        end
      end
    end else if (st[i] == 1) begin
      if (s_arvalid[own[i]] && m_arready) st[i] = 2;
    end else if (m_rvalid && s_rready[own[i]] && m_rlast) begin
      st[i] = 0;
      own[i] = -1;
    end
  endtask

  always @(negedge clock) begin : cmp
    exp_t e;
    e = model_out(0);
    chk("A.grant", a_grant, e.grant);
    chk("A.busy", a_busy, e.busy);
    chk("A.m_ar", {a_m_arvalid, a_m_araddr, a_m_arid, a_m_arlen, a_m_arsize, a_m_arburst}, e.mar);
    chk("A.m_rready", a_m_rready, e.mrr);
    chk("A.s_arready", a_s_arready, e.sar);
    chk("A.s_rvalid", a_s_rvalid, e.srv);
    chk("A.s_rlast", a_s_rlast, e.srl);
    chk("A.s_rdata", a_s_rdata, e.srd);
    chk("A.s_rresp", a_s_rresp, e.srr);
    chk("A.s_rid", a_s_rid, e.sri);
    e = model_out(1);
    chk("B.grant", b_grant, e.grant);
    chk("B.busy", b_busy, e.busy);
    chk("B.m_ar", {b_m_arvalid, b_m_araddr, b_m_arid, b_m_arlen, b_m_arsize, b_m_arburst}, e.mar);
    chk("B.m_rready", b_m_rready, e.mrr);
    chk("B.s_arready", b_s_arready, e.sar);
    chk("B.s_rvalid", b_s_rvalid, e.srv);
    chk("B.s_rlast", b_s_rlast, e.srl);
    chk("B.s_rdata", b_s_rdata, e.srd);
    chk("B.s_rresp", b_s_rresp, e.srr);
    chk("B.s_rid", b_s_rid, e.sri);
    model_step(0);
    model_step(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_arvalid = '0;
    cyc(2);
    chk("rst.outputs", {a_grant, a_busy, b_grant, b_busy, a_m_arvalid, b_m_arvalid, a_s_rvalid, b_s_rvalid}, '0);
    reset = 1'b0;
  endtask

  task automatic set_len(input logic [7:0] l);
    for (int i = 0; i < 5; i++) s_arlen[i*8 +: 8] = l;
  endtask

  logic [4:0] rr_seq[12] = '{5'b00001, 5'b00001, 5'b00000, 5'b00010, 5'b00010, 5'b00000,
                             5'b00100, 5'b00100, 5'b00000, 5'b00001, 5'b00001, 5'b00000};
  int hs, beat;
  bit done;

  initial begin
    for (int i = 0; i < 5; i++) begin
      s_araddr[i*32 +: 32] = 32'h1000_0000 + i * 256;
      s_arid[i*4 +: 4] = 4'(i + 3);
      s_arsize[i*3 +: 3] = 3'd2;
      s_arburst[i*2 +: 2] = 2'b01;
    end
    set_len(8'd0);
    do_reset();
    // Fixed priority picks slot 1 of 3'b110; slot 2 waits for slot 1's rlast.
    m_arready = 1'b1;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    s_rready = 5'b11111;
    m_rdata = 32'h55;
    s_arvalid = 5'b00110;
    cyc(1);
    chk("p032.grant", a_grant, 3'b010);
    chk("p032.araddr", a_m_araddr, 32'h1000_0100);
    chk("p032.rr_grant", b_grant, 5'b00010);
    cyc(1);
    s_arvalid = 5'b00100;
    chk("p032.rvalid", a_s_rvalid, 3'b010);
    chk("p032.rdata", a_s_rdata[63:32], 32'h55);
    cyc(1);
    chk("p032.idle_gap", {a_grant, a_busy}, 4'b0000);
    cyc(1);
    chk("p032.slot2", a_grant, 3'b100);
    chk("p032.rr_slot2", b_grant, 5'b00100);
    cyc(1);
    s_arvalid = '0;
    cyc(1);
    // Continuous requests from slots 0..2 with single-beat bursts.
    do_reset();
    s_arvalid = 5'b00111;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk("p033.rr_seq", b_grant, rr_seq[k]);
      chk("p033.fp_seq", a_grant, (k % 3 == 2) ? 3'b000 : 3'b001);
    end
    s_arvalid = '0;
    cyc(1);
    // Eight-beat burst with toggling rvalid and a two-cycle rready stall.
    do_reset();
    s_arlen[7:0] = 8'd7;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    s_arvalid = 5'b00001;
    cyc(2);
    s_arvalid = '0;
    hs = 0;
    beat = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      m_rvalid = (k % 2 == 0);
      s_rready = (k == 3 || k == 4) ? 5'b00000 : 5'b11111;
      m_rlast = (beat == 7);
      m_rdata = 32'hB000 + beat;
      #2;
      chk("p034.busy", {a_busy, b_busy}, 2'b11);
      if (a_s_rvalid[0] && s_rready[0]) begin
        hs++;
        beat++;
        if (a_s_rlast[0]) done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    chk("p034.done", done, 1'b1);
    chk("p034.beats", hs, 8);
    chk("p034.idle_after", {a_busy, b_busy}, 2'b00);
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    s_rready = 5'b11111;
    set_len(8'd0);
    // Address phase stalled; a competing request must not disturb the owner.
    do_reset();
    m_arready = 1'b0;
    s_arvalid = 5'b00001;
    cyc(1);
    s_arvalid = 5'b00011;
    repeat (5) begin
      cyc(1);
      chk("p035.grant", a_grant, 3'b001);
      chk("p035.arready", a_s_arready, 3'b000);
      chk("p035.rr_grant", b_grant, 5'b00001);
    end
    m_arready = 1'b1;
    #1;
    chk("p035.arready_owner", a_s_arready, 3'b001);
    chk("p035.rr_arready_owner", b_s_arready, 5'b00001);
    cyc(1);
    s_arvalid = 5'b00010;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    cyc(2);
    chk("p035.next_owner", a_grant, 3'b010);
    cyc(1);
    s_arvalid = '0;
    cyc(1);
    // Reset during beat 3 of an eight-beat burst.
    do_reset();
    s_arlen[23:16] = 8'd7;
    m_rlast = 1'b0;
    m_rdata = 32'hCAFE;
    s_arvalid = 5'b00100;
    cyc(2);
    s_arvalid = '0;
    cyc(2);
    reset = 1'b1;
    #1;
    chk("p036.fp_zero", {a_grant, a_busy, a_s_rvalid, a_m_rready, a_s_rdata}, '0);
    chk("p036.rr_zero", {b_grant, b_busy, b_s_rvalid, b_m_rready, b_s_rdata}, '0);
    cyc(1);
    reset = 1'b0;
    m_rlast = 1'b1;
    set_len(8'd0);
    s_arvalid = 5'b00111;
    cyc(1);
    chk("p036.rr_first", b_grant, 5'b00001);
    chk("p036.fp_first", a_grant, 3'b001);
    cyc(1);
    s_arvalid = '0;
    cyc(1);
    // Round-robin wrap-around on five slots.
    do_reset();
    s_arvalid = 5'b01000;
    cyc(1);
    chk("p037.slot3", b_grant, 5'b01000);
    cyc(1);
    s_arvalid = '0;
    cyc(1);
    s_arvalid = 5'b01010;
    cyc(1);
    chk("p037.wrap", b_grant, 5'b00010);
    cyc(1);
    s_arvalid = '0;
    cyc(1);
    s_arvalid = 5'b00101;
    cyc(1);
    chk("p037.ptr2", b_grant, 5'b00100);
    cyc(1);
    s_arvalid = '0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
